// File: rtl/mux_scan_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mux_scan_pkg
// Shared types and constants for the mux scan controller.
//   state_t : controller FSM states (2-bit encoding)
//   CNT_W   : width of the settle (dwell) counter
//   idx_w() : width of the sample index counter for a given word size
// -----------------------------------------------------------------------------
package mux_scan_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETTLE   = 2'd1,
    SAMPLE   = 2'd2,
    WAIT_OUT = 2'd3
  } state_t;

  localparam int CNT_W = 8;

  function automatic int idx_w(input int word_w);
    return $clog2(word_w);
  endfunction

endpackage

// File: rtl/mux_scan_dwell_cnt.sv
// -----------------------------------------------------------------------------
// mux_scan_dwell_cnt
// Settle-time counter for the mux scan controller. Counts up while 'inc' is
// high and flags the last settle cycle (count == DWELL-1). On that cycle the
// counter returns to zero, so it never runs past its terminal value.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (highest priority)
//   load       : load 'load_val'
//   load_val   : value to load
//   inc        : count enable
//   term       : high when the count equals DWELL-1
// -----------------------------------------------------------------------------
module mux_scan_dwell_cnt
  import mux_scan_pkg::*;
#(
  parameter int DWELL = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             inc,
  output logic             term
);

  localparam logic [CNT_W-1:0] TERM_VAL = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] cnt;

  assign term = (cnt == TERM_VAL);

  // Clear beats load beats increment; the terminal cycle wraps back to zero
  // so the next settle period starts from a clean count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (inc) begin
      cnt <= term ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// -----------------------------------------------------------------------------
// mux_scan_ctrl
// Drives the select line of a 2:1 mux, alternating 0,1,0,1..., waits DWELL
// cycles after each change, samples the mux output once per setting and packs
// WORD_W consecutive samples into a word offered over valid/ready.
// Parameters:
//   DWELL  : settle cycles after each sel change (1..255)
//   WORD_W : samples per word (even, >= 2); bit 0 is always a sel=0 sample
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   en          : scan enable, looked at in IDLE and at word completion
//   y           : mux output being sampled
//   sel         : mux select
//   word        : packed samples, bit i = sample i
//   word_valid  : word holds an unconsumed value
//   word_ready  : consumer accepts word when word_valid && word_ready
//   busy        : controller is not idle
// -----------------------------------------------------------------------------
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int DWELL  = 2,
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              y,
  output logic              sel,
  output logic [WORD_W-1:0] word,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              busy
);

  localparam int                IDX_W    = idx_w(WORD_W);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORD_W - 1);

  state_t              state, next_state;
  logic [IDX_W-1:0]    idx;
  logic [WORD_W-1:0]   shreg;
  logic                term;
  logic                last_sample;
  logic                slot_free;
  logic                cnt_clr;
  logic                cnt_load;

  assign last_sample = (idx == LAST_IDX);
  // The output register can take a new word if it is empty or being drained
  // in this very cycle, which is what gives back-to-back words.
  assign slot_free   = !word_valid || word_ready;
  assign busy        = (state != IDLE);

  // The counter sits at zero outside SETTLE so every settle period starts
  // fresh regardless of which state it was entered from.
  assign cnt_load = (state == IDLE);
  assign cnt_clr  = (state == SAMPLE) || (state == WAIT_OUT);

  mux_scan_dwell_cnt #(
    .DWELL (DWELL)
  ) u_dwell_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .load_val ('0),
    .inc      (state == SETTLE),
    .term     (term)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (en) next_state = SETTLE;
      end
      SETTLE: begin
        if (term) next_state = SAMPLE;
      end
      SAMPLE: begin
        if (!last_sample) begin
          next_state = SETTLE;
        end else if (slot_free) begin
          next_state = en ? SETTLE : IDLE;
        end else begin
          next_state = WAIT_OUT;
        end
      end
      WAIT_OUT: begin
        if (word_ready) next_state = en ? SETTLE : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Sampling, select toggling and the output register. An accept with no
  // reload clears word_valid; a reload in the same cycle overrides the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel        <= 1'b0;
      word       <= '0;
      word_valid <= 1'b0;
      idx        <= '0;
      shreg      <= '0;
    end else begin
      if (word_valid && word_ready) begin
        word_valid <= 1'b0;
      end
      case (state)
        SAMPLE: begin
          shreg[idx] <= y;
          sel        <= ~sel;
          if (!last_sample) begin
            idx <= idx + IDX_W'(1);
          end else if (slot_free) begin
            word       <= {y, shreg[WORD_W-2:0]};
            word_valid <= 1'b1;
            idx        <= '0;
          end
        end
        WAIT_OUT: begin
          if (word_ready) begin
            word       <= shreg;
            word_valid <= 1'b1;
            idx        <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mux_scan_ctrl
// Bench for mux_scan_ctrl. dut0 uses the default DWELL=2, dut1 uses DWELL=1.
// The mux is modelled as y = sel ? b : a, or y is driven with random bits.
// Expected words come from sample timing: sample k of word w is taken at
// edge w*WORD_W*(DWELL+1) + (k+1)*(DWELL+1) counted from the enabling edge.
// -----------------------------------------------------------------------------
module tb_mux_scan_ctrl;

  localparam int D0 = 2;
  localparam int D1 = 1;
  localparam int W  = 8;

  logic         clk;
  logic         rst_n;
  logic         en0, en1;
  logic         y0, y1;
  logic         sel0, sel1;
  logic [W-1:0] word0, word1;
  logic         wv0, wv1;
  logic         wr0, wr1;
  logic         busy0, busy1;

  logic         a, b;
  logic         mux_mode;
  logic         y_rand;

  int checks;
  int errors;

  assign y0 = mux_mode ? (sel0 ? b : a) : y_rand;
  assign y1 = sel1 ? b : a;

  mux_scan_ctrl #(.DWELL(D0), .WORD_W(W)) dut0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en0),
    .y          (y0),
    .sel        (sel0),
    .word       (word0),
    .word_valid (wv0),
    .word_ready (wr0),
    .busy       (busy0)
  );

  mux_scan_ctrl #(.DWELL(D1), .WORD_W(W)) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en1),
    .y          (y1),
    .sel        (sel1),
    .word       (word1),
    .word_valid (wv1),
    .word_ready (wr1),
    .busy       (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle0();
    int n;
    n = 0;
    while ((busy0 !== 1'b0 || wv0 !== 1'b0) && n < 300) begin
      tick();
      n++;
    end
    checks++;
    if (busy0 !== 1'b0 || wv0 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle0_timeout: busy=%b valid=%b expected 0 0", busy0, wv0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en0 = 0; en1 = 0; wr0 = 1; wr1 = 1;
    a = 0; b = 0; mux_mode = 1; y_rand = 0;
    #3;
    checks++;
    if ({sel0, wv0, busy0} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_ctrl0: sel/valid/busy=%b expected 000", {sel0, wv0, busy0});
    end
    checks++;
    if (word0 !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_word0: got %h expected 00", word0);
    end
    checks++;
    if ({sel1, wv1, busy1} !== 3'b000 || word1 !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_dut1: ctrl=%b word=%h expected 000 00", {sel1, wv1, busy1}, word1);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_idle: busy0=%b busy1=%b expected 0 0", busy0, busy1);
    end
  endtask

  task automatic test_first_word();
    int n;
    bit busy_drop;
    a = 1; b = 0; mux_mode = 1; wr0 = 1;
    en0 = 1;
    tick();
    n = 0;
    busy_drop = 0;
    while (wv0 !== 1'b1 && n < 100) begin
      if (busy0 !== 1'b1) busy_drop = 1;
      tick();
      n++;
    end
    checks++;
    if (n != W * (D0 + 1)) begin
      errors++;
      $display("[TB] FAIL first_latency: got %0d edges expected %0d", n, W * (D0 + 1));
    end
    checks++;
    if (word0 !== 8'h55) begin
      errors++;
      $display("[TB] FAIL first_word: got %h expected 55", word0);
    end
    checks++;
    if (busy_drop) begin
      errors++;
      $display("[TB] FAIL first_busy: busy dropped to 0 expected 1 throughout");
    end
    en0 = 0;
    wait_idle0();
  endtask

  task automatic test_dwell1_back_to_back();
    int n;
    int got;
    a = 0; b = 1; wr1 = 1;
    en1 = 1;
    tick();
    got = 0;
    for (n = 1; n <= 70; n++) begin
      if (n == 40) en1 = 0;
      tick();
      if (wv1 === 1'b1) begin
        got++;
        checks++;
        if (n != got * W * (D1 + 1) || word1 !== 8'hAA) begin
          errors++;
          $display("[TB] FAIL dwell1_word%0d: edge %0d word %h expected edge %0d word aa",
                   got, n, word1, got * W * (D1 + 1));
        end
      end
    end
    checks++;
    if (got != 3 || busy1 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL dwell1_count: got %0d words busy=%b expected 3 words busy=0", got, busy1);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    bit unstable;
    bit sel_moved;
    a = 1; b = 0; mux_mode = 1; wr0 = 0;
    en0 = 1;
    tick();
    n = 0;
    while (wv0 !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n != W * (D0 + 1) || word0 !== 8'h55) begin
      errors++;
      $display("[TB] FAIL bp_word1: edge %0d word %h expected edge %0d word 55", n, word0, W * (D0 + 1));
    end
    unstable = 0;
    sel_moved = 0;
    while (n < 60) begin
      tick();
      n++;
      if (wv0 !== 1'b1 || word0 !== 8'h55) unstable = 1;
      if (n >= 2 * W * (D0 + 1) && sel0 !== 1'b0) sel_moved = 1;
    end
    checks++;
    if (unstable) begin
      errors++;
      $display("[TB] FAIL bp_stable: word %h valid %b changed expected 55 1 held", word0, wv0);
    end
    checks++;
    if (sel_moved || busy0 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_wait: sel moved=%b busy=%b expected sel frozen at 0 busy=1", sel_moved, busy0);
    end
    wr0 = 1;
    tick();
    wr0 = 0;
    checks++;
    if (wv0 !== 1'b1 || word0 !== 8'h55 || busy0 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_reload: valid=%b word=%h busy=%b expected 1 55 1", wv0, word0, busy0);
    end
    tick();
    checks++;
    if (wv0 !== 1'b1 || word0 !== 8'h55) begin
      errors++;
      $display("[TB] FAIL bp_word2_hold: valid=%b word=%h expected 1 55", wv0, word0);
    end
    wr0 = 1;
    en0 = 0;
    wait_idle0();
  endtask

  task automatic test_en_drop();
    int n;
    bit early;
    a = 1; b = 0; mux_mode = 1; wr0 = 1;
    en0 = 1;
    tick();
    n = 0;
    while (wv0 !== 1'b1 && n < 100) begin
      if (n == 3 * (D0 + 1)) en0 = 0;
      tick();
      n++;
    end
    checks++;
    if (n != W * (D0 + 1) || word0 !== 8'h55) begin
      errors++;
      $display("[TB] FAIL endrop_word: edge %0d word %h expected edge %0d word 55", n, word0, W * (D0 + 1));
    end
    checks++;
    if (busy0 !== 1'b0 || sel0 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL endrop_idle: busy=%b sel=%b expected 0 0", busy0, sel0);
    end
    early = 0;
    tick();
    for (int i = 0; i < 10; i++) begin
      if (wv0 !== 1'b0 || busy0 !== 1'b0) early = 1;
      tick();
    end
    checks++;
    if (early) begin
      errors++;
      $display("[TB] FAIL endrop_quiet: valid=%b busy=%b expected 0 0 after word", wv0, busy0);
    end
  endtask

  task automatic test_reset_mid_word();
    int n;
    a = 1; b = 0; mux_mode = 1; wr0 = 1;
    en0 = 1;
    tick();
    for (n = 1; n <= 5 * (D0 + 1) + 1; n++) tick();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({sel0, wv0, busy0} !== 3'b000 || word0 !== 8'h00) begin
      errors++;
      $display("[TB] FAIL midreset_async: sel/valid/busy=%b word=%h expected 000 00",
               {sel0, wv0, busy0}, word0);
    end
    tick();
    rst_n = 1'b1;
    tick();
    n = 0;
    while (wv0 !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n != W * (D0 + 1) || word0 !== 8'h55) begin
      errors++;
      $display("[TB] FAIL midreset_fresh: edge %0d word %h expected edge %0d word 55", n, word0, W * (D0 + 1));
    end
    en0 = 0;
    wait_idle0();
  endtask

  task automatic test_async_y();
    bit           ylog[$];
    logic [W-1:0] expw;
    int           per;
    int           wd;
    per = W * (D0 + 1);
    mux_mode = 0; wr0 = 1;
    ylog.delete();
    en0 = 1;
    y_rand = 1'($urandom_range(0, 1));
    ylog.push_back(y_rand);
    tick();
    for (int t = 1; t <= 3 * per; t++) begin
      if (t == 3 * per - 2) en0 = 0;
      y_rand = 1'($urandom_range(0, 1));
      ylog.push_back(y_rand);
      tick();
      if (t % per == 0) begin
        wd = t / per - 1;
        for (int k = 0; k < W; k++) expw[k] = ylog[wd * per + (k + 1) * (D0 + 1)];
        checks++;
        if (wv0 !== 1'b1 || word0 !== expw) begin
          errors++;
          $display("[TB] FAIL async_word%0d: valid=%b word=%h expected 1 %h", wd, wv0, word0, expw);
        end
      end
    end
    mux_mode = 1;
    wait_idle0();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_first_word();
    test_dwell1_back_to_back();
    test_back_to_back();
    test_en_drop();
    test_reset_mid_word();
    test_async_y();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
